ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch.sv | 87 ++++++++
 tb/tb_ifetch.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Instruction fetch unit: 16x13 program memory, IDLE/FETCH/HALT sequencer,
// registered instruction output with one-cycle read latency.
module ifetch #(
  parameter logic [3:0] HALT_OP  = 4'b1101,
  parameter logic [3:0] RESET_PC = 4'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        progEn,
  input  logic [3:0]  progAddr,
  input  logic [12:0] progData,
  input  logic        run,
  input  logic        stall,
  input  logic        brTaken,
  input  logic [3:0]  brTarget,
  output logic [12:0] instOut,
  output logic        instValid,
  output logic [3:0]  pc,
  output logic        halted
);

  typedef enum logic [1:0] {StIdle, StFetch, StHalt} state_e;

  state_e      state;
  logic [12:0] mem [16];
  logic [12:0] rd_word;

  assign rd_word = mem[pc];

  // Memory has no reset so a mid-run reset leaves the loaded program intact.
  always_ff @(posedge clk) begin
    if (progEn && (state == StIdle)) begin
      mem[progAddr] <= progData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      pc        <= RESET_PC;
      instOut   <= 13'b0;
      instValid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          instValid <= 1'b0;
          if (run) begin
            state <= StFetch;
          end
        end
        StFetch: begin
          if (!run) begin
            state     <= StIdle;
            pc        <= RESET_PC;
            instValid <= 1'b0;
          end else if (brTaken) begin
            // Flush the in-flight slot; fetch resumes at the target next cycle.
            pc        <= brTarget;
            instOut   <= 13'b0;
            instValid <= 1'b0;
          end else if (!stall) begin
            instOut   <= rd_word;
            instValid <= 1'b1;
            pc        <= pc + 4'd1;
            if (rd_word[12:9] == HALT_OP) begin
              state  <= StHalt;
              halted <= 1'b1;
            end
          end
        end
        StHalt: begin
          instValid <= 1'b0;
          if (!run) begin
            state  <= StIdle;
            pc     <= RESET_PC;
            halted <= 1'b0;
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Directed, table-driven bench for ifetch: fetch/halt/stall/branch/wrap
// sequences, plus hand-written program-write and async-reset sequences.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        progEn = 1'b0;
  logic [3:0]  progAddr = 4'h0;
  logic [12:0] progData = 13'h0;
  logic        run = 1'b0;
  logic        stall = 1'b0;
  logic        brTaken = 1'b0;
  logic [3:0]  brTarget = 4'h0;
  logic [12:0] instOut;
  logic        instValid;
  logic [3:0]  pc;
  logic        halted;

  int checks = 0;
  int errors = 0;

  localparam logic [12:0] M0  = 13'b0001001010011;
  localparam logic [12:0] M1  = 13'b0011001011100;
  localparam logic [12:0] M2  = 13'b1101000000000;
  localparam logic [12:0] M14 = 13'b1001011111000;
  localparam logic [12:0] M15 = 13'h0ABC;

  typedef struct packed {
    logic        run;
    logic        stall;
    logic        br;
    logic [3:0]  tgt;
    logic [12:0] inst;
    logic        valid;
    logic [3:0]  pc;
    logic        halted;
  } vec_t;

  vec_t vecs [21];

  ifetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .progEn    (progEn),
    .progAddr  (progAddr),
    .progData  (progData),
    .run       (run),
    .stall     (stall),
    .brTaken   (brTaken),
    .brTarget  (brTarget),
    .instOut   (instOut),
    .instValid (instValid),
    .pc        (pc),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [12:0] e_inst, input logic e_valid,
                         input logic [3:0] e_pc, input logic e_halted);
    chk({tag, ".instOut"}, instOut, e_inst);
    chk({tag, ".instValid"}, {12'b0, instValid}, {12'b0, e_valid});
    chk({tag, ".pc"}, {9'b0, pc}, {9'b0, e_pc});
    chk({tag, ".halted"}, {12'b0, halted}, {12'b0, e_halted});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [3:0] a, input logic [12:0] d);
    progEn   = 1'b1;
    progAddr = a;
    progData = d;
    step();
    progEn   = 1'b0;
  endtask

  initial begin
    //            run  stl  br   tgt    inst    v     pc     h
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, 13'h0, 1'b0, 4'd0,  1'b0}; // IDLE->FETCH
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'h0, M0,    1'b1, 4'd1,  1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 4'h0, M1,    1'b1, 4'd2,  1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 4'h0, M2,    1'b1, 4'd3,  1'b1}; // halt word presented
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 4'h7, M2,    1'b0, 4'd3,  1'b1}; // HALT ignores stall/br
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'h0, M2,    1'b0, 4'd0,  1'b0}; // HALT->IDLE
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 4'h0, M2,    1'b0, 4'd0,  1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 4'h0, M0,    1'b1, 4'd1,  1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 4'h0, M0,    1'b1, 4'd1,  1'b0}; // stall 1
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 4'h0, M0,    1'b1, 4'd1,  1'b0}; // stall 2
    vecs[10] = '{1'b1, 1'b0, 1'b0, 4'h0, M1,    1'b1, 4'd2,  1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 4'h0, M2,    1'b1, 4'd3,  1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 4'h0, M2,    1'b0, 4'd0,  1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 4'h0, M2,    1'b0, 4'd0,  1'b0};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 4'hE, 13'h0, 1'b0, 4'd14, 1'b0}; // branch beats stall
    vecs[15] = '{1'b1, 1'b0, 1'b0, 4'h0, M14,   1'b1, 4'd15, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 4'h0, M15,   1'b1, 4'd0,  1'b0}; // pc wrap
    vecs[17] = '{1'b1, 1'b0, 1'b0, 4'h0, M0,    1'b1, 4'd1,  1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 4'h0, M0,    1'b0, 4'd0,  1'b0};
    vecs[19] = '{1'b1, 1'b0, 1'b0, 4'h0, M0,    1'b0, 4'd0,  1'b0};
    vecs[20] = '{1'b0, 1'b0, 1'b1, 4'h5, M0,    1'b0, 4'd0,  1'b0}; // run=0 beats branch

    #1 rst_n = 1'b0;
    #2;
    chk_all("reset", 13'h0, 1'b0, 4'd0, 1'b0);
    step();
    rst_n = 1'b1;

    prog(4'd0, M0);
    prog(4'd1, M1);
    prog(4'd2, M2);
    for (int i = 3; i < 14; i++) prog(4'(i), {4'b0010, 5'b0, 4'(i)});
    prog(4'd14, M14);
    prog(4'd15, M15);
    chk_all("idle_after_load", 13'h0, 1'b0, 4'd0, 1'b0);

    for (int i = 0; i < 21; i++) begin
      run      = vecs[i].run;
      stall    = vecs[i].stall;
      brTaken  = vecs[i].br;
      brTarget = vecs[i].tgt;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].inst, vecs[i].valid, vecs[i].pc, vecs[i].halted);
    end
    stall   = 1'b0;
    brTaken = 1'b0;

    // Program write attempted during FETCH must be dropped.
    run = 1'b1;
    step();
    progEn   = 1'b1;
    progAddr = 4'd0;
    progData = 13'h1FFF;
    stall    = 1'b1;
    step();
    progEn = 1'b0;
    stall  = 1'b0;
    step();
    chk_all("prog_in_fetch", M0, 1'b1, 4'd1, 1'b0);

    // Asynchronous reset mid-FETCH, then restart from pc 0.
    step();
    chk_all("pre_reset", M1, 1'b1, 4'd2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_reset_fetch", 13'h0, 1'b0, 4'd0, 1'b0);
    #1 rst_n = 1'b1;
    step();
    chk_all("restart_enter", 13'h0, 1'b0, 4'd0, 1'b0);
    step();
    chk_all("restart_m0", M0, 1'b1, 4'd1, 1'b0);
    step();
    chk_all("restart_m1", M1, 1'b1, 4'd2, 1'b0);
    step();
    chk_all("restart_m2", M2, 1'b1, 4'd3, 1'b1);

    // Asynchronous reset mid-HALT.
    step();
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_reset_halt", 13'h0, 1'b0, 4'd0, 1'b0);
    run = 1'b0;
    #1 rst_n = 1'b1;
    step();
    chk_all("idle_final", 13'h0, 1'b0, 4'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
